// File: rtl/fir_seq_filter.sv
// fir_seq_filter: sequential FIR filter with a single time-multiplexed signed MAC.
// Keeps an NTAPS-deep window of signed samples (window[0] newest), reads coefficients
// from an external synchronous ROM with one cycle of read latency, and scales the
// accumulator by a runtime arithmetic right shift before formatting to OUT_W bits.
// Build option: define FIR_SAT_EN to saturate the output; otherwise it wraps.
module fir_seq_filter #(
    parameter int IN_W   = 24,
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int NTAPS  = 16,
    parameter int OUT_W  = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sample_valid_i,
    input  logic [IN_W-1:0]            sample_i,
    output logic                       ready_o,
    output logic                       busy_o,
    output logic [$clog2(NTAPS)-1:0]   coef_addr_o,
    input  logic [COEF_W-1:0]          coef_data_i,
    input  logic [5:0]                 gain_i,
    input  logic                       ovr_clr_i,
    output logic                       out_valid_o,
    output logic [OUT_W-1:0]           out_o,
    output logic                       overrun_o
);

    localparam int AW     = $clog2(NTAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + $clog2(NTAPS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_OUT
    } state_t;

    state_t                     state;
    state_t                     state_nxt;
    logic                       accept;
    logic                       last_addr;
    logic                       overrun_evt;
    logic                       sample_valid_q;
    logic                       mac_en;
    logic [AW-1:0]              mac_idx;
    logic signed [DATA_W-1:0]   window [NTAPS];
    logic signed [ACC_W-1:0]    acc;
    logic signed [PROD_W-1:0]   prod;
    logic signed [ACC_W-1:0]    acc_sh;
    logic [OUT_W-1:0]           out_fmt;
    logic                       unused_bits;

    assign ready_o   = (state == S_IDLE);
    assign busy_o    = ~ready_o;
    assign last_addr = (coef_addr_o == AW'(NTAPS - 1));

    // A held strobe is one pending request that is served once the filter is idle;
    // only a fresh strobe (low on the previous edge) arriving while busy is a drop.
    assign overrun_evt = sample_valid_i & ~sample_valid_q & busy_o;

    // Product of the coefficient returned this cycle and the tap addressed one cycle ago.
    assign prod   = $signed(coef_data_i) * window[mac_idx];
    assign acc_sh = acc >>> gain_i;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register
            // samples pre-edge values regardless of statement order.
            state <= state_nxt;
        end
    end

    // Next-state decode: IDLE -> RUN -> DRAIN -> OUT -> IDLE.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal unassigned
        // (which would infer a latch).
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                if (sample_valid_i) begin
                    accept    = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN:   if (last_addr) state_nxt = S_DRAIN;
            S_DRAIN: state_nxt = S_OUT;
            S_OUT:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output formatting of the shifted accumulator.
    always_comb begin
        out_fmt = acc_sh[OUT_W-1:0];
`ifdef FIR_SAT_EN
        if (acc_sh[ACC_W-1:OUT_W-1] != {(ACC_W-OUT_W+1){acc_sh[ACC_W-1]}}) begin
            out_fmt = acc_sh[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                      : {1'b0, {(OUT_W-1){1'b1}}};
        end
`endif
    end

    // Bits of the raw sample and shifted accumulator that never reach an output.
    generate
        if (IN_W > DATA_W) begin : g_low_bits
`ifdef FIR_SAT_EN
            assign unused_bits = ^sample_i[IN_W-DATA_W-1:0];
`else
            assign unused_bits = ^sample_i[IN_W-DATA_W-1:0] ^ ^acc_sh[ACC_W-1:OUT_W];
`endif
        end else begin : g_no_low_bits
`ifdef FIR_SAT_EN
            assign unused_bits = 1'b0;
`else
            assign unused_bits = ^acc_sh[ACC_W-1:OUT_W];
`endif
        end
    endgenerate

    // Datapath: window shift, coefficient addressing, MAC pipeline, output and overrun flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the window is a register array, not RAM, and its contents are
            // visible in the next outputs, so it is cleared with the rest of the state.
            for (int k = 0; k < NTAPS; k++) window[k] <= '0;
            acc            <= '0;
            coef_addr_o    <= '0;
            mac_en         <= 1'b0;
            mac_idx        <= '0;
            out_o          <= '0;
            out_valid_o    <= 1'b0;
            overrun_o      <= 1'b0;
            sample_valid_q <= 1'b0;
        end else begin
            sample_valid_q <= sample_valid_i;
            out_valid_o    <= 1'b0;

            if (accept) begin
                for (int k = NTAPS - 1; k > 0; k--) window[k] <= window[k-1];
                window[0]   <= $signed(sample_i[IN_W-1 -: DATA_W]);
                coef_addr_o <= '0;
            end else if (state == S_RUN && !last_addr) begin
                coef_addr_o <= coef_addr_o + AW'(1);
            end

            // Delay the tap index by one cycle to line up with the ROM read data.
            mac_en  <= (state == S_RUN);
            mac_idx <= coef_addr_o;

            if (accept) begin
                acc <= '0;
            end else if (mac_en) begin
                acc <= acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
            end

            if (state == S_OUT) begin
                out_o       <= out_fmt;
                out_valid_o <= 1'b1;
            end

            // A new overrun outranks a simultaneous clear.
            if (overrun_evt) begin
                overrun_o <= 1'b1;
            end else if (ovr_clr_i) begin
                overrun_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fir_seq_filter.sv
// Self-checking bench for fir_seq_filter (NTAPS=4, 24-bit input, 16-bit data/coef/out).
// Table of directed single-sample vectors plus hand-written multi-cycle sequences for
// overrun, reset mid-run and back-to-back operation. Honors FIR_SAT_EN like the RTL.
module tb_fir_seq_filter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sample_valid = 1'b0;
    logic [23:0] sample = '0;
    logic        ready;
    logic        busy;
    logic [1:0]  coef_addr;
    logic [15:0] coef_data = '0;
    logic [5:0]  gain = '0;
    logic        ovr_clr = 1'b0;
    logic        out_valid;
    logic [15:0] out;
    logic        overrun;

    logic [15:0] rom [4];

    int n_checks = 0;
    int n_fail   = 0;

    fir_seq_filter #(
        .IN_W  (24),
        .DATA_W(16),
        .COEF_W(16),
        .NTAPS (4),
        .OUT_W (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .sample_valid_i(sample_valid),
        .sample_i      (sample),
        .ready_o       (ready),
        .busy_o        (busy),
        .coef_addr_o   (coef_addr),
        .coef_data_i   (coef_data),
        .gain_i        (gain),
        .ovr_clr_i     (ovr_clr),
        .out_valid_o   (out_valid),
        .out_o         (out),
        .overrun_o     (overrun)
    );

    always #5 clk = ~clk;

    // Coefficient ROM with one cycle of read latency.
    always @(posedge clk) coef_data <= rom[coef_addr];

    typedef struct {
        logic             rst_first;
        logic [3:0][15:0] h;
        logic [5:0]       gain;
        logic [23:0]      sample;
        logic [15:0]      exp;
    } vec_t;

    localparam logic [3:0][15:0] H_RAMP = {16'd4, 16'd3, 16'd2, 16'd1};
    localparam logic [3:0][15:0] H_NEG  = {4{16'hFFFF}};
    localparam logic [3:0][15:0] H_HALF = {4{16'h4000}};

`ifdef FIR_SAT_EN
    localparam logic [15:0] E_P2 = 16'h7FFF;
    localparam logic [15:0] E_P3 = 16'h7FFF;
    localparam logic [15:0] E_P4 = 16'h7FFF;
    localparam logic [15:0] E_N2 = 16'h8000;
`else
    localparam logic [15:0] E_P2 = 16'hFFFE;
    localparam logic [15:0] E_P3 = 16'h7FFD;
    localparam logic [15:0] E_P4 = 16'hFFFC;
    localparam logic [15:0] E_N2 = 16'h0000;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load_rom(input logic [3:0][15:0] h);
        for (int k = 0; k < 4; k++) rom[k] = h[k];
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset        = 1'b1;
        sample_valid = 1'b0;
        ovr_clr      = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_out", 32'(out), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_ready", 32'(ready), 32'h1);
        check("rst_coef_addr", 32'(coef_addr), 32'h0);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Waits (bounded) for the out_valid pulse; returns edges counted since the
    // acceptance edge. Caller is at the negedge right after acceptance.
    task automatic wait_out(output int edges);
        edges = 0;
        while (!out_valid && edges < 20) begin
            @(negedge clk);
            edges++;
        end
    endtask

    // Presents one sample at a negedge, expects acceptance on the next edge.
    task automatic run_sample(input logic [23:0] s, input logic [15:0] exp, input string name);
        int edges;
        for (int i = 0; i < 20 && !ready; i++) @(negedge clk);
        check({name, "_ready"}, 32'(ready), 32'h1);
        sample       = s;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        check({name, "_busy"}, 32'(busy), 32'h1);
        wait_out(edges);
        check({name, "_latency"}, 32'(edges), 32'd6);
        check({name, "_out"}, 32'(out), 32'(exp));
    endtask

    initial begin
        vec_t vecs[$];
        int   edges;
        int   acc_e [4];
        int   ov_e  [4];
        logic [15:0] ov_v [4];
        int   na;
        int   no;
        int   pulses;
        logic seen_ovr;

        // Directed vectors: optional reset, coefficients, gain, sample, expected out_o.
        vecs.push_back('{1'b1, H_RAMP, 6'd0,  24'h000100, 16'd1});
        vecs.push_back('{1'b0, H_RAMP, 6'd0,  24'h000000, 16'd2});
        vecs.push_back('{1'b0, H_RAMP, 6'd0,  24'h000000, 16'd3});
        vecs.push_back('{1'b0, H_RAMP, 6'd0,  24'h000000, 16'd4});
        vecs.push_back('{1'b1, H_NEG,  6'd0,  24'hFFFF00, 16'd1});
        vecs.push_back('{1'b0, H_NEG,  6'd0,  24'hFFFF00, 16'd2});
        vecs.push_back('{1'b0, H_NEG,  6'd0,  24'hFFFF00, 16'd3});
        vecs.push_back('{1'b0, H_NEG,  6'd0,  24'hFFFF00, 16'd4});
        vecs.push_back('{1'b1, H_HALF, 6'd14, 24'h7FFF00, 16'h7FFF});
        vecs.push_back('{1'b0, H_HALF, 6'd14, 24'h7FFF00, E_P2});
        vecs.push_back('{1'b0, H_HALF, 6'd14, 24'h7FFF00, E_P3});
        vecs.push_back('{1'b0, H_HALF, 6'd14, 24'h7FFF00, E_P4});
        vecs.push_back('{1'b1, H_HALF, 6'd14, 24'h800000, 16'h8000});
        vecs.push_back('{1'b0, H_HALF, 6'd14, 24'h800000, E_N2});
        // Shifts at or beyond the accumulator width give sign fill.
        vecs.push_back('{1'b1, H_RAMP, 6'd40, 24'hFFFF00, 16'hFFFF});
        vecs.push_back('{1'b0, H_RAMP, 6'd63, 24'h7FFF00, 16'h0000});
        vecs.push_back('{1'b0, H_RAMP, 6'd1,  24'h000000, 16'h7FFD});
        vecs.push_back('{1'b0, H_RAMP, 6'd2,  24'h000000, 16'h5FFE});

        load_rom(H_RAMP);
        do_reset();

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst_first) do_reset();
            load_rom(vecs[i].h);
            gain = vecs[i].gain;
            run_sample(vecs[i].sample, vecs[i].exp, $sformatf("vec%0d", i));
            check($sformatf("vec%0d_overrun", i), 32'(overrun), 32'h0);
        end
        check("addr_hold", 32'(coef_addr), 32'd3);

        // Overrun: a strobe two cycles after acceptance is dropped and flagged.
        do_reset();
        load_rom(H_RAMP);
        gain         = 6'd0;
        sample       = 24'h000100;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        @(negedge clk);
        sample       = 24'h000500;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        check("ovr_set", 32'(overrun), 32'h1);
        edges = 0;
        while (!out_valid && edges < 20) begin
            @(negedge clk);
            edges++;
        end
        check("ovr_latency", 32'(edges + 2), 32'd6);
        check("ovr_out", 32'(out), 32'd1);
        run_sample(24'h000000, 16'd2, "ovr_next");
        check("ovr_sticky", 32'(overrun), 32'h1);

        // Clear and a new overrun on the same edge: the set wins.
        sample       = 24'h000000;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        @(negedge clk);
        sample_valid = 1'b1;
        ovr_clr      = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        ovr_clr      = 1'b0;
        check("ovr_set_wins", 32'(overrun), 32'h1);
        wait_out(edges);
        check("ovr_run2_out", 32'(out), 32'd3);
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        check("ovr_clear", 32'(overrun), 32'h0);

        // Reset mid-run: no pulse, window cleared.
        do_reset();
        load_rom(H_RAMP);
        run_sample(24'h000300, 16'd3, "mid_pre");
        sample       = 24'h000200;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        check("mid_no_pulse", 32'(pulses), 32'd0);
        check("mid_out_zero", 32'(out), 32'h0);
        check("mid_ready", 32'(ready), 32'h1);
        run_sample(24'h000100, 16'd1, "mid_post");

        // Back-to-back with the strobe held high.
        do_reset();
        load_rom(H_RAMP);
        na       = 0;
        no       = 0;
        seen_ovr = 1'b0;
        sample       = 24'h000100;
        sample_valid = 1'b1;
        for (int t = 0; t < 30; t++) begin
            if (ready && na < 4) begin
                acc_e[na] = t + 1;
                na++;
            end
            if (out_valid && no < 4) begin
                ov_e[no] = t;
                ov_v[no] = out;
                no++;
            end
            if (overrun) seen_ovr = 1'b1;
            @(negedge clk);
        end
        sample_valid = 1'b0;
        check("b2b_accepts", 32'(na), 32'd4);
        check("b2b_outputs", 32'(no), 32'd4);
        check("b2b_overrun", 32'(seen_ovr), 32'h0);
        if (na == 4 && no == 4) begin
            for (int i = 0; i < 3; i++)
                check($sformatf("b2b_period%0d", i), 32'(acc_e[i+1] - acc_e[i]), 32'd7);
            for (int i = 0; i < 4; i++)
                check($sformatf("b2b_latency%0d", i), 32'(ov_e[i] - acc_e[i]), 32'd6);
            check("b2b_out0", 32'(ov_v[0]), 32'd1);
            check("b2b_out1", 32'(ov_v[1]), 32'd3);
            check("b2b_out2", 32'(ov_v[2]), 32'd6);
            check("b2b_out3", 32'(ov_v[3]), 32'd10);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
